// File: rtl/modular_multiplier_if.sv
// Start/done handshake and operand/result bus shared by the field-arithmetic blocks.
// The master launches an operation; the slave multiplier reports result, done and busy.
interface modular_multiplier_if #(
    parameter int unsigned WIDTH = 256
) ();
    logic             i_start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;

    modport master (
        output i_start, A, B, p,
        input  result, done, busy
    );

    modport slave (
        input  i_start, A, B, p,
        output result, done, busy
    );
endinterface

// File: rtl/modular_multiplier.sv
// Bit-serial interleaved modular multiplier: result = (A * B) mod p, one multiplier bit per
// cycle MSB first, with a WIDTH+1 bit datapath so no carry is lost when p is close to 2^WIDTH.
module modular_multiplier #(
    parameter int unsigned WIDTH = 256
) (
    input logic                  i_clk,
    input logic                  i_rst,
    modular_multiplier_if.slave  bus
);

    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             done_q, done_d;
    logic             start_q;
    logic             launch;

    logic [WIDTH:0]   dbl;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] addend;

    // Only a rising edge of i_start is a request; a held level never relaunches.
    assign launch = bus.i_start & ~start_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            p_q      <= p_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            start_q  <= bus.i_start;
        end
    end

    // One interleaved step: acc = (2*acc + B[idx]*A) mod p, each half reduced once since acc, A < p.
    always_comb begin
        dbl = {acc_q, 1'b0};
        if (dbl >= {1'b0, p_q}) begin
            dbl = dbl - {1'b0, p_q};
        end
        addend = b_q[idx_q] ? a_q : '0;
        sum    = dbl + {1'b0, addend};
        if (sum >= {1'b0, p_q}) begin
            sum = sum - {1'b0, p_q};
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        acc_d    = acc_q;
        result_d = result_q;
        idx_d    = idx_q;
        done_d   = done_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (launch) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    p_d     = bus.p;
                    acc_d   = '0;
                    idx_d   = IdxW'(WIDTH - 1);
                    done_d  = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = sum[WIDTH-1:0];
                idx_d = idx_q - IdxW'(1);
                if (idx_q == '0) begin
                    result_d = sum[WIDTH-1:0];
                    done_d   = 1'b1;
                    state_d  = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.busy   = (state_q == StRun);

endmodule

// File: tb/tb_modular_multiplier.sv
// Self-checking bench for modular_multiplier: a cycle-level transaction model built on 512-bit
// arithmetic is compared against the DUT every cycle, plus directed literal checks.
module tb_modular_multiplier;

    localparam int unsigned W = 256;
    localparam logic [W-1:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [W-1:0] TWO_POW_255 =
        256'h80000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000;
    localparam logic [W-1:0] TWO_POW_256_MOD_P = 256'h1_000003D1;
    localparam logic [W-1:0] T3_A =
        256'h25738ad3_1f0c6e94_a2b7d5c8_3e41f907_6d28b1a4_c95e0f36_87b2d4e1_09fa5b3e;
    localparam logic [W-1:0] T3_B =
        256'hbc3a3769_4d81e2f0_6c93a7b5_1e08d4c2_f7a96b13_52e0c8d9_a41f7e36_0b5d8984;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   check_en = 1'b0;

    modular_multiplier_if #(.WIDTH(W)) bus ();

    modular_multiplier #(.WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] m);
        logic [2*W-1:0] prod;
        logic [2*W-1:0] rem;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        rem  = prod % {{W{1'b0}}, m};
        return rem[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_fe();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) begin
            v[i*32 +: 32] = $urandom;
        end
        if (v >= P) v = v - P;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: an operation launched on a rising start takes WIDTH more edges.
    logic [W-1:0] m_result, m_golden;
    logic         m_done, m_busy, m_start_q;
    int           m_left;

    always @(posedge clk) begin
        if (rst) begin
            m_result  <= '0;
            m_done    <= 1'b0;
            m_busy    <= 1'b0;
            m_start_q <= 1'b0;
            m_left    <= 0;
        end else begin
            m_start_q <= bus.i_start;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy   <= 1'b0;
                    m_done   <= 1'b1;
                    m_result <= m_golden;
                end
            end else if (bus.i_start && !m_start_q) begin
                m_golden <= golden(bus.A, bus.B, bus.p);
                m_busy   <= 1'b1;
                m_done   <= 1'b0;
                m_left   <= W;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("cyc_done", W'(bus.done), W'(m_done));
            check("cyc_busy", W'(bus.busy), W'(m_busy));
            check("cyc_result", bus.result, m_result);
        end
    end

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                          input bit hold);
        @(negedge clk);
        bus.A       = a;
        bus.B       = b;
        bus.p       = m;
        bus.i_start = 1'b1;
        @(negedge clk);
        if (!hold) bus.i_start = 1'b0;
    endtask

    // Returns edges elapsed since the launch edge until done is seen high.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!bus.done && cycles < W + 20) begin
            @(negedge clk);
            cycles++;
        end
        if (!bus.done) begin
            errors++;
            $display("FAIL wait_done: timeout after %0d cycles", cycles);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp);
        int cyc;
        launch(a, b, P, 1'b0);
        check({name, "_busy"}, W'(bus.busy), W'(1));
        check({name, "_done_low"}, W'(bus.done), W'(0));
        wait_done(cyc);
        check({name, "_latency"}, W'(cyc), W'(W));
        check({name, "_result"}, bus.result, exp);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic [W-1:0] ra, rb, old_res, t5_a, t5_b;

        bus.i_start = 1'b0;
        bus.A       = '0;
        bus.B       = '0;
        bus.p       = P;

        // Pin the model to hand-computed values.
        check("model_2x3", golden(256'd2, 256'd3, P), 256'd6);
        check("model_2pow256", golden(TWO_POW_255, 256'd2, P), TWO_POW_256_MOD_P);
        check("model_pm1_sq", golden(P - 1, P - 1, P), 256'd1);

        repeat (2) @(negedge clk);
        check_en = 1'b1;
        check("reset_done", W'(bus.done), W'(0));
        check("reset_busy", W'(bus.busy), W'(0));
        check("reset_result", bus.result, '0);
        rst = 1'b0;

        // Basic product with single-cycle start pulse.
        run_op("t1", 256'd2, 256'd3, 256'd6);
        check("t1_busy_after", W'(bus.busy), W'(0));

        // Wrap and carry cases.
        run_op("t2_carry", TWO_POW_255, 256'd2, TWO_POW_256_MOD_P);
        run_op("t2_pm1", P - 1, P - 1, 256'd1);
        run_op("t2_a0", 256'd0, P - 1, 256'd0);
        run_op("t2_b0", T3_A, 256'd0, 256'd0);

        // Start held high for 3000 ns: exactly one operation.
        launch(T3_A, T3_B, P, 1'b1);
        wait_done(cyc);
        check("t3_latency", W'(cyc), W'(W));
        repeat (300 - 1 - cyc) @(negedge clk);
        check("t3_done_held", W'(bus.done), W'(1));
        check("t3_busy", W'(bus.busy), W'(0));
        check("t3_result", bus.result, golden(T3_A, T3_B, P));
        bus.i_start = 1'b0;

        // Reset at iteration 100, with a coincident start edge that must be ignored.
        launch(T3_B, T3_A, P, 1'b0);
        repeat (99) @(negedge clk);
        rst = 1'b1;
        bus.i_start = 1'b1;
        @(negedge clk);
        check("t4_rst_done", W'(bus.done), W'(0));
        check("t4_rst_busy", W'(bus.busy), W'(0));
        check("t4_rst_result", bus.result, '0);
        rst = 1'b0;
        bus.i_start = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_idle_busy", W'(bus.busy), W'(0));
        run_op("t4_relaunch", 256'd5, 256'd7, 256'd35);

        // Start edge and operand changes mid-run must not disturb the running operation.
        t5_a = rand_fe();
        t5_b = rand_fe();
        launch(t5_a, t5_b, P, 1'b0);
        repeat (49) @(negedge clk);
        bus.i_start = 1'b1;
        bus.A = rand_fe();
        bus.B = rand_fe();
        bus.p = 256'd1000;
        @(negedge clk);
        bus.i_start = 1'b0;
        wait_done(cyc);
        check("t5_orig_result", bus.result, golden(t5_a, t5_b, P));
        old_res = bus.result;
        ra = rand_fe();
        rb = rand_fe();
        launch(ra, rb, P, 1'b0);
        check("t5_done_drop", W'(bus.done), W'(0));
        check("t5_result_kept", bus.result, old_res);
        wait_done(cyc);
        check("t5_new_latency", W'(cyc), W'(W));
        check("t5_new_result", bus.result, golden(ra, rb, P));

        // Back-to-back random operands.
        for (int i = 0; i < 200; i++) begin
            ra = rand_fe();
            rb = rand_fe();
            run_op("t6", ra, rb, golden(ra, rb, P));
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
